// File: rtl/reg_dest_scoreboard_if.sv
// reg_dest_scoreboard_if: issue, write-back and status signals of the destination-register scoreboard
interface reg_dest_scoreboard_if #(
    parameter int ADDR_W = 5,
    parameter int TOT_W  = 6
);
    localparam int NREGS = 2 ** ADDR_W;
    logic              iss_valid;
    logic              iss_ready;
    logic              iss_we;
    logic [ADDR_W-1:0] iss_dest;
    logic [ADDR_W-1:0] iss_rs;
    logic [ADDR_W-1:0] iss_rt;
    logic              iss_rs_use;
    logic              iss_rt_use;
    logic              wb_valid;
    logic [ADDR_W-1:0] wb_dest;
    logic              stall;
    logic [NREGS-1:0]  pend_vec;
    logic [TOT_W-1:0]  tot_pend;
    logic              err_underflow;
    modport master (
        output iss_valid, iss_we, iss_dest, iss_rs, iss_rt, iss_rs_use, iss_rt_use, wb_valid, wb_dest,
        input  iss_ready, stall, pend_vec, tot_pend, err_underflow
    );
    modport slave (
        input  iss_valid, iss_we, iss_dest, iss_rs, iss_rt, iss_rs_use, iss_rt_use, wb_valid, wb_dest,
        output iss_ready, stall, pend_vec, tot_pend, err_underflow
    );
endinterface

// File: rtl/reg_dest_scoreboard.sv
// reg_dest_scoreboard: per-register pending-write counters with RAW stall; optional WB_BYPASS_EN lets the last retiring write-back unblock a reader in the same cycle
module reg_dest_scoreboard #(
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 2,
    parameter int TOT_W  = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    reg_dest_scoreboard_if.slave  bus
);
    localparam int NREGS = 2 ** ADDR_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [TOT_W-1:0] TOT_MAX = '1;
    logic [CNT_W-1:0] cnt [NREGS];
    logic [TOT_W-1:0] tot;
    logic             err;
    logic [NREGS-1:0] inc;
    logic [NREGS-1:0] dec;
    logic [NREGS-1:0] pend;
    logic             rs_busy;
    logic             rt_busy;
    logic             stall;
    logic             full_dest;
    logic             accept;
    logic             underflow;
    // RAW hazard on either used, non-zero source that still has a write outstanding
    always_comb begin
        rs_busy = bus.iss_rs_use && bus.iss_rs != '0 && cnt[bus.iss_rs] != '0;
        rt_busy = bus.iss_rt_use && bus.iss_rt != '0 && cnt[bus.iss_rt] != '0;
`ifdef WB_BYPASS_EN
        rs_busy = rs_busy && !(bus.wb_valid && bus.wb_dest == bus.iss_rs && cnt[bus.iss_rs] == CNT_W'(1));
        rt_busy = rt_busy && !(bus.wb_valid && bus.wb_dest == bus.iss_rt && cnt[bus.iss_rt] == CNT_W'(1));
`else
        rs_busy = rs_busy;
        rt_busy = rt_busy;
`endif
        stall = bus.iss_valid && (rs_busy || rt_busy);
    end
    // Issue handshake: blocked by a hazard, a saturated destination counter or a saturated total
    always_comb begin
        full_dest = (bus.iss_we && bus.iss_dest != '0 && cnt[bus.iss_dest] == CNT_MAX) || tot == TOT_MAX;
        accept    = bus.iss_valid && !stall && !full_dest;
        underflow = bus.wb_valid && bus.wb_dest != '0 && cnt[bus.wb_dest] == '0;
    end
    // Per-register increment/decrement strobes; register 0 is never tracked
    always_comb begin
        inc  = '0;
        dec  = '0;
        pend = '0;
        for (int i = 1; i < NREGS; i++) begin
            inc[i]  = accept && bus.iss_we && bus.iss_dest == ADDR_W'(i);
            dec[i]  = bus.wb_valid && bus.wb_dest == ADDR_W'(i) && cnt[i] != '0;
            pend[i] = cnt[i] != '0;
        end
    end
    // Counter state; a same-register inc and dec cancel, and neither can wrap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) cnt[i] <= '0;
            tot <= '0;
            err <= 1'b0;
        end else begin
            for (int i = 1; i < NREGS; i++) begin
                if (inc[i] && !dec[i]) cnt[i] <= cnt[i] + CNT_W'(1);
                else if (dec[i] && !inc[i]) cnt[i] <= cnt[i] - CNT_W'(1);
            end
            if (|inc && !(|dec)) tot <= tot + TOT_W'(1);
            else if (|dec && !(|inc)) tot <= tot - TOT_W'(1);
            if (underflow) err <= 1'b1;
        end
    end
    assign bus.stall         = stall;
    assign bus.iss_ready     = !stall && !full_dest;
    assign bus.pend_vec      = pend;
    assign bus.tot_pend      = tot;
    assign bus.err_underflow = err;
endmodule

// File: tb/tb_reg_dest_scoreboard.sv
// tb_reg_dest_scoreboard: directed checks of reset, RAW stall, saturation, simultaneous update, $zero and underflow
module tb_reg_dest_scoreboard;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int n_checks = 0;
    int n_fail = 0;
    reg_dest_scoreboard_if bus ();
    reg_dest_scoreboard dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;
`ifdef WB_BYPASS_EN
    localparam logic BYPASS = 1'b1;
`else
    localparam logic BYPASS = 1'b0;
`endif
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic idle();
        bus.iss_valid = 0; bus.iss_we = 0; bus.iss_dest = 0; bus.iss_rs = 0; bus.iss_rt = 0;
        bus.iss_rs_use = 0; bus.iss_rt_use = 0; bus.wb_valid = 0; bus.wb_dest = 0;
    endtask
    task automatic issue_wr(input logic [4:0] d);
        bus.iss_valid = 1; bus.iss_we = 1; bus.iss_dest = d; bus.iss_rs_use = 0; bus.iss_rt_use = 0;
    endtask
    task automatic wb(input logic [4:0] d);
        bus.wb_valid = 1; bus.wb_dest = d;
    endtask
    initial begin
        idle();
        tick(); tick();
        check("rst_pend", bus.pend_vec, 0);
        check("rst_tot", bus.tot_pend, 0);
        check("rst_err", bus.err_underflow, 0);
        check("rst_ready", bus.iss_ready, 1);
        rst_n = 1;
        tick();
        // RAW on r5
        issue_wr(5);
        #1 check("raw_first_ready", bus.iss_ready, 1);
        tick();
        bus.iss_we = 0; bus.iss_rs = 5; bus.iss_rs_use = 1;
        #1 check("raw_stall", bus.stall, 1);
        check("raw_ready", bus.iss_ready, 0);
        check("raw_pend", bus.pend_vec, 64'h20);
        check("raw_tot", bus.tot_pend, 1);
        tick();
        wb(5);
        #1 check("raw_wb_stall", bus.stall, !BYPASS);
        check("raw_wb_ready", bus.iss_ready, BYPASS);
        tick();
        bus.wb_valid = 0;
        #1 check("raw_after_stall", bus.stall, 0);
        check("raw_after_ready", bus.iss_ready, 1);
        check("raw_after_pend", bus.pend_vec, 0);
        check("raw_after_tot", bus.tot_pend, 0);
        idle(); tick();
        // saturation of r7
        issue_wr(7);
        tick(); tick(); tick();
        #1 check("sat_ready", bus.iss_ready, 0);
        check("sat_stall", bus.stall, 0);
        check("sat_tot", bus.tot_pend, 3);
        check("sat_pend", bus.pend_vec, 64'h80);
        tick();
        check("sat_hold_tot", bus.tot_pend, 3);
        wb(7);
        #1 check("sat_wb_ready", bus.iss_ready, 0);
        tick();
        bus.wb_valid = 0;
        #1 check("sat_after_ready", bus.iss_ready, 1);
        check("sat_after_tot", bus.tot_pend, 2);
        idle(); wb(7); tick(); tick(); idle();
        #1 check("sat_drain_tot", bus.tot_pend, 0);
        check("sat_drain_pend", bus.pend_vec, 0);
        // simultaneous issue and write-back
        issue_wr(3); tick();
        issue_wr(3); wb(3); tick();
        #1 check("sim_same_tot", bus.tot_pend, 1);
        check("sim_same_pend", bus.pend_vec, 64'h8);
        issue_wr(4); wb(3); tick();
        #1 check("sim_diff_pend", bus.pend_vec, 64'h10);
        check("sim_diff_tot", bus.tot_pend, 1);
        idle(); wb(4); tick(); idle();
        #1 check("sim_drain_tot", bus.tot_pend, 0);
        // register 0
        issue_wr(0); bus.iss_rs_use = 1; bus.iss_rt_use = 1; wb(0);
        #1 check("r0_stall", bus.stall, 0);
        check("r0_ready", bus.iss_ready, 1);
        tick();
        #1 check("r0_stall_after", bus.stall, 0);
        check("r0_tot", bus.tot_pend, 0);
        check("r0_pend", bus.pend_vec, 0);
        check("r0_err", bus.err_underflow, 0);
        idle();
        // underflow on r9 with r2 pending
        issue_wr(2); tick(); idle();
        wb(9); tick(); idle();
        #1 check("uf_err", bus.err_underflow, 1);
        check("uf_tot", bus.tot_pend, 1);
        check("uf_pend", bus.pend_vec, 64'h4);
        tick();
        check("uf_sticky", bus.err_underflow, 1);
        wb(2); tick(); idle();
        #1 check("uf_drain_tot", bus.tot_pend, 0);
        // fill total counter to 63 with r10..r30 at three writes each
        for (int r = 10; r <= 30; r++) begin
            issue_wr(5'(r));
            tick(); tick(); tick();
        end
        issue_wr(31);
        #1 check("tot_full", bus.tot_pend, 63);
        check("tot_full_ready", bus.iss_ready, 0);
        bus.iss_we = 0;
        #1 check("tot_full_nowe_ready", bus.iss_ready, 0);
        bus.iss_rt = 10; bus.iss_rt_use = 1;
        #1 check("rt_stall", bus.stall, 1);
        tick();
        check("tot_hold", bus.tot_pend, 63);
        check("full_pend", bus.pend_vec, 64'h7FFF_FC00);
        // asynchronous reset away from the clock edge with state loaded
        #2 rst_n = 0;
        #1 check("arst_pend", bus.pend_vec, 0);
        check("arst_tot", bus.tot_pend, 0);
        check("arst_err", bus.err_underflow, 1'b0);
        check("arst_stall", bus.stall, 0);
        check("arst_ready", bus.iss_ready, 1);
        idle(); tick();
        rst_n = 1;
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/reg_dest_scoreboard.md
Name: reg_dest_scoreboard

Overview:
- Consumer side of the write-register address select (rt/rd 5-bit destination) in the 16-bit MIPS pipeline.
- Decodes the selected destination address into per-register pending-write tracking.
- Tracks in-flight writes from issue to write-back and raises a stall when an issuing instruction reads (rs/rt) a register that still has a write outstanding.
- Sits between decode/issue and the register-file write-back port.

Parameters:
- ADDR_W, 5, register address width; NREGS = 2**ADDR_W.
- CNT_W, 2, width of each per-register pending counter; max in-flight writes per register = 2**CNT_W-1.
- TOT_W, 6, width of the total-pending counter.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- iss_valid  in  1  issue stage presents an instruction.
- iss_ready  out  1  scoreboard accepts the issue this cycle.
- iss_we  in  1  issuing instruction writes a register.
- iss_dest  in  ADDR_W  destination address (output of the rt/rd select).
- iss_rs  in  ADDR_W  source register 1.
- iss_rt  in  ADDR_W  source register 2.
- iss_rs_use  in  1  rs is actually read.
- iss_rt_use  in  1  rt is actually read.
- wb_valid  in  1  write-back retires one write this cycle.
- wb_dest  in  ADDR_W  register being written back.
- stall  out  1  RAW hazard on rs/rt (combinational).
- pend_vec  out  NREGS  bit i = 1 when counter[i] != 0.
- tot_pend  out  TOT_W  total outstanding writes.
- err_underflow  out  1  sticky: write-back to a register with no pending write.

Behaviour:
- Reset (async, rst_n=0): all counters 0, tot_pend=0, pend_vec=0, err_underflow=0. Outputs are valid immediately on reset assertion.
- Register 0 ($zero):
  - Never tracked.
  - Issue with iss_dest=0 is accepted but does not change any counter.
  - wb_dest=0 is ignored and does not set the error flag.
  - Reads of register 0 never stall.
- stall = iss_valid & ((iss_rs_use & rs!=0 & cnt[rs]!=0) | (iss_rt_use & rt!=0 & cnt[rt]!=0)). Purely combinational from current state and inputs.
- full_dest = iss_we & iss_dest!=0 & cnt[iss_dest]==max, or tot_pend==max.
- iss_ready = !stall & !full_dest.
- accept = iss_valid & iss_ready.
- Per-register update each rising edge:
  - inc[i] = accept & iss_we & iss_dest==i & i!=0.
  - dec[i] = wb_valid & wb_dest==i & i!=0 & cnt[i]!=0.
  - inc & dec on the same register: count unchanged.
  - Only inc: +1. Only dec: -1. Counters never wrap.
- tot_pend: +1 on any inc, -1 on any dec; simultaneous inc and dec leaves it unchanged (including different registers).
- wb_valid with wb_dest!=0 and cnt[wb_dest]==0: no counter change, err_underflow set to 1 next edge, held until reset.
- Latency:
  - An accepted issue shows in pend_vec/stall the next cycle.
  - A write-back clears its pending effect the next cycle, unless WB_BYPASS_EN is defined.
- Back-to-back writes to the same register are allowed up to max. Write-backs must retire in order per register; the count only is tracked.
- Reset mid-operation discards all in-flight state; pipeline flush is handled by the owner asserting rst_n.

Optional Feature:
WB_BYPASS_EN:
- Defined: the stall term for a source register is suppressed when wb_valid & wb_dest==src & cnt[src]==1. The write-back retiring the last pending write unblocks the reader in the same cycle; this relies on the register file's write-before-read.
- iss_ready uses the bypassed stall.
- Not defined: stall depends only on registered counts; one extra stall cycle.

Test Plan:
- Reset: rst_n=0 mid-cycle with counters nonzero -> pend_vec=0, tot_pend=0, err_underflow=0, iss_ready=1 immediately and asynchronously.
- RAW: issue we=1 dest=5; next cycle issue rs=5 rs_use=1 -> stall=1, iss_ready=0. wb_dest=5 -> without bypass stall drops the cycle after; with WB_BYPASS_EN stall=0 in the wb cycle.
- Saturation: issue 3 writes to r7 with CNT_W=2; 4th issue dest=7 -> iss_ready=0, cnt[7]=3. One wb r7 -> iss_ready=1 next cycle.
- Simultaneous: cnt[3]=1, same cycle accept dest=3 and wb_dest=3 -> cnt[3] stays 1, tot_pend unchanged. Accept dest=4 with wb_dest=3 -> pend_vec[3]=0, pend_vec[4]=1, tot_pend unchanged.
- Register 0: issue dest=0 and rs=0 use=1, and wb_dest=0 -> no stall, tot_pend=0, err_underflow=0.
- Underflow: wb_dest=9 with cnt[9]=0 -> err_underflow=1 next cycle and stays 1. Counters unchanged, tot_pend unchanged.
